// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word at a time over req/ack,
// presents decoded fields to the controller and selects the next PC from pcsrc/jump.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request imem at pc, wait for ack
// S_ISSUE | instruction register presented, wait for instr_ready
// S_HALT  | HALT retired; fetch stopped until reset
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [2:0]      op,
    output logic [2:0]      rs,
    output logic [2:0]      rt,
    output logic [2:0]      rd,
    output logic [3:0]      funct,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc,
    input  logic            pcsrc,
    input  logic            jump,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [PC_W-1:0] pcplus1;
    logic [PC_W-1:0] imm_ext;
    logic [PC_W-1:0] next_pc;
    logic            is_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Jump keeps the upper bits of pc+1 and replaces the low 13 with the target.
    always_comb begin
        pcplus1 = pc_q + PC_W'(1);
        imm_ext = {{(PC_W-7){ir_q[6]}}, ir_q[6:0]};
        if (jump)
            next_pc = {pcplus1[PC_W-1:13], ir_q[12:0]};
        else if (pcsrc)
            next_pc = pcplus1 + imm_ext;
        else
            next_pc = pcplus1;
    end

    assign is_halt = (ir_q[15:13] == 3'b111) && (ir_q[3:0] == 4'b1111);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign pc          = pc_q;

    assign op    = ir_q[15:13];
    assign rs    = ir_q[12:10];
    assign rt    = ir_q[9:7];
    assign rd    = ir_q[6:4];
    assign funct = ir_q[3:0];
    assign imm   = {{9{ir_q[6]}}, ir_q[6:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions are queued when memory acks
// and popped when the DUT presents them; a second instance starts at 0xFFFF.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op, rs, rt, rd;
    logic [3:0]  funct;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        pcsrc;
    logic        jump;
    logic        halted;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_valid;
    logic [2:0]  w_op, w_rs, w_rt, w_rd;
    logic [3:0]  w_funct;
    logic [15:0] w_imm;
    logic [15:0] w_pc;
    logic        w_halted;
    logic        w_ack;
    logic [15:0] w_rdata;
    logic        w_ready;
    logic        w_pcsrc;
    logic        w_jump;

    typedef struct {
        logic [15:0] word;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .pc(pc), .pcsrc(pcsrc), .jump(jump), .halted(halted)
    );

    // Ack-immediate memory returning 0x0000 everywhere, consumer always ready.
    assign w_ack   = w_req;
    assign w_rdata = 16'h0000;
    assign w_ready = 1'b1;
    assign w_pcsrc = 1'b0;
    assign w_jump  = 1'b0;

    fetch_unit #(.PC_W(16), .RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .op(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd), .funct(w_funct), .imm(w_imm),
        .pc(w_pc), .pcsrc(w_pcsrc), .jump(w_jump), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n, input logic ack_during);
        reset       = 1'b1;
        imem_ack    = ack_during;
        imem_rdata  = 16'hBEEF;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
        repeat (n) @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_req",    imem_req,    1'b1);
        chk("rst_addr",   imem_addr,   16'h0000);
        chk("rst_valid",  instr_valid, 1'b0);
        chk("rst_halted", halted,      1'b0);
        chk("rst_fields", {op, rs, rt, rd, funct}, 16'h0000);
        chk("rst_imm",    imm,         16'h0000);
        chk("rst_pc",     pc,          16'h0000);
    endtask

    // One instruction: stall ack_wait cycles, ack, hold ready low ready_wait cycles
    // (with pcsrc/jump toggling and stray acks), then consume with br/jp.
    task automatic fetch_one(input logic [15:0] word, input logic [15:0] addr,
                             input int ack_wait, input int ready_wait,
                             input logic br, input logic jp);
        exp_t e;
        exp_t got;
        logic [15:0] w;
        chk("req", imem_req, 1'b1);
        chk("addr", imem_addr, addr);
        chk("valid_lo", instr_valid, 1'b0);
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("req_hold", imem_req, 1'b1);
            chk("addr_hold", imem_addr, addr);
            chk("valid_stall", instr_valid, 1'b0);
        end
        imem_ack    = 1'b1;
        imem_rdata  = word;
        instr_ready = (ready_wait == 0);
        pcsrc       = br;
        jump        = jp;
        e.word = word;
        e.addr = addr;
        sb.push_back(e);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("valid_hi", instr_valid, 1'b1);
        chk("req_lo", imem_req, 1'b0);
        got = sb.pop_front();
        w = got.word;
        chk("op", op, w[15:13]);
        chk("rs", rs, w[12:10]);
        chk("rt", rt, w[9:7]);
        chk("rd", rd, w[6:4]);
        chk("funct", funct, w[3:0]);
        chk("imm", imm, {{9{w[6]}}, w[6:0]});
        chk("pc", pc, got.addr);
        for (int i = 0; i < ready_wait; i++) begin
            instr_ready = 1'b0;
            pcsrc       = ~pcsrc;
            jump        = i[0];
            imem_ack    = 1'b1;
            imem_rdata  = ~word;
            @(negedge clk);
            chk("bp_valid", instr_valid, 1'b1);
            chk("bp_req", imem_req, 1'b0);
            chk("bp_fields", {op, rs, rt, rd, funct}, w);
            chk("bp_pc", pc, got.addr);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        pcsrc       = br;
        jump        = jp;
        @(negedge clk);
        pcsrc = 1'b0;
        jump  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;

        do_reset(2, 1'b1);
        chk_reset_state();
        chk("w_req0", w_req, 1'b1);
        chk("w_addr0", w_addr, 16'hFFFF);
        @(negedge clk);
        chk("w_valid", w_valid, 1'b1);
        chk("w_pc", w_pc, 16'hFFFF);
        chk("stall_addr", imem_addr, 16'h0000);
        @(negedge clk);
        chk("w_req1", w_req, 1'b1);
        chk("w_wrap_addr", w_addr, 16'h0000);

        // sequential fetch of zeros
        for (int a = 0; a < 4; a++) fetch_one(16'h0000, 16'(a), 0, 0, 1'b0, 1'b0);
        fetch_one(16'h007E, 16'h0004, 0, 0, 1'b1, 1'b0);
        fetch_one(16'h0000, 16'h0003, 3, 4, 1'b0, 1'b0);
        fetch_one(16'h1FFF, 16'h0004, 0, 0, 1'b0, 1'b1);
        fetch_one(16'h0000, 16'h1FFF, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h0005, 16'h2000, 0, 0, 1'b0, 1'b1);
        fetch_one(16'h4123, 16'h2005, 1, 2, 1'b1, 1'b1);
        chk("jump_wins", imem_addr, 16'h2123);

        do_reset(1, 1'b0);
        chk_reset_state();
        fetch_one(16'h007E, 16'h0000, 0, 0, 1'b1, 1'b0);
        fetch_one(16'h0000, 16'hFFFF, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h007C, 16'h0001, 0, 0, 1'b1, 1'b0);
        chk("br_wrap", imem_addr, 16'hFFFE);

        fetch_one(16'hE00F, 16'hFFFE, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            chk("halted", halted, 1'b1);
            chk("halt_req", imem_req, 1'b0);
            chk("halt_valid", instr_valid, 1'b0);
            chk("halt_pc", pc, 16'hFFFE);
        end
        imem_ack = 1'b0;

        do_reset(1, 1'b0);
        chk_reset_state();
        fetch_one(16'h1234, 16'h0000, 0, 0, 1'b0, 1'b0);
        chk("pre_rst_addr", imem_addr, 16'h0001);
        do_reset(1, 1'b1);
        chk_reset_state();
        fetch_one(16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0);
        chk("post_rst_next", imem_addr, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
